// File: rtl/tcn_pkg.sv
// Shared TCN package: default geometry and the tap sequencer state type.
package tcn_pkg;

  localparam int TCN_DEPTH                = 48;
  localparam int TCN_PHYSICALBITSPERWORD  = 80;
  localparam int TCN_KMAX                 = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EMIT = 2'd1,
    ST_DONE = 2'd2
  } tcn_tap_state_e;

endpackage

// File: rtl/tcn_tap_sequencer.sv
// TCN tap sequencer: streams the dilated kernel taps of one sequence out of
// the history window, oldest first, zero-padding taps that fall before the
// window start.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for start_i; configuration latched on acceptance
// EMIT    | a tap is registered on tap_*; advances on each handshake
// DONE    | one-cycle done_o pulse, then back to IDLE
module tcn_tap_sequencer
  import tcn_pkg::*;
#(
  parameter int DEPTH               = TCN_DEPTH,
  parameter int PHYSICALBITSPERWORD = TCN_PHYSICALBITSPERWORD,
  parameter int KMAX                = TCN_KMAX
) (
  input  logic                                           clk_i,
  input  logic                                           rst_ni,
  input  logic [0:DEPTH-1][PHYSICALBITSPERWORD-1:0]      window_i,
  input  logic                                           start_i,
  input  logic [$clog2(DEPTH)-1:0]                       dilation_i,
  input  logic [$clog2(KMAX+1)-1:0]                      num_taps_i,
  output logic                                           tap_valid_o,
  input  logic                                           tap_ready_i,
  output logic [PHYSICALBITSPERWORD-1:0]                 tap_data_o,
  output logic                                           tap_pad_o,
  output logic                                           tap_last_o,
  output logic                                           busy_o,
  output logic                                           done_o
);

  localparam int DW = $clog2(DEPTH);
  localparam int NW = $clog2(KMAX + 1);
  // Wide enough for (KMAX-1)*(DEPTH-1) so padded offsets never alias.
  localparam int OW = $clog2(DEPTH) + $clog2(KMAX) + 1;

  tcn_tap_state_e                 r_state;
  logic [DW-1:0]                  r_dil;
  logic [NW-1:0]                  r_rem;
  logic [OW-1:0]                  r_off;
  logic                           r_valid;
  logic                           r_pad;
  logic [PHYSICALBITSPERWORD-1:0] r_data;

  logic                           w_hs;
  logic [OW-1:0]                  w_n_m1;
  logic [OW-1:0]                  w_off0;
  logic [OW-1:0]                  w_off_step;
  logic [OW-1:0]                  w_sel_off;
  logic                           w_pad;
  logic [DW-1:0]                  w_idx;
  logic [PHYSICALBITSPERWORD-1:0] w_word;

  // Offset of the next tap to register and the window word it selects.
  // In IDLE this is the first tap of a new sequence, otherwise the tap that
  // follows the one currently presented.
  always_comb begin
    w_hs       = r_valid & tap_ready_i;
    w_n_m1     = OW'(num_taps_i) - OW'(1);
    w_off0     = w_n_m1 * OW'(dilation_i);
    w_off_step = r_off - OW'(r_dil);
    w_sel_off  = (r_state == ST_IDLE) ? w_off0 : w_off_step;
    w_pad      = (w_sel_off > OW'(DEPTH - 1));
    w_idx      = DW'(DEPTH - 1) - w_sel_off[DW-1:0];
    w_word     = w_pad ? '0 : window_i[w_idx];
  end

  // Sequencing FSM and the registered tap presented to the consumer.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ST_IDLE;
      r_dil   <= '0;
      r_rem   <= '0;
      r_off   <= '0;
      r_valid <= 1'b0;
      r_pad   <= 1'b0;
      r_data  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start_i) begin
            r_dil <= dilation_i;
            if (num_taps_i != '0) begin
              r_state <= ST_EMIT;
              r_rem   <= num_taps_i - NW'(1);
              r_off   <= w_off0;
              r_valid <= 1'b1;
              r_pad   <= w_pad;
              r_data  <= w_word;
            end else begin
              r_state <= ST_DONE;
              r_rem   <= '0;
              r_off   <= '0;
            end
          end
        end
        ST_EMIT: begin
          if (w_hs) begin
            if (r_rem == '0) begin
              r_state <= ST_DONE;
              r_valid <= 1'b0;
              r_pad   <= 1'b0;
              r_data  <= '0;
            end else begin
              r_rem  <= r_rem - NW'(1);
              r_off  <= w_off_step;
              r_pad  <= w_pad;
              r_data <= w_word;
            end
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  // Every output is decoded from registers only; tap_ready_i never reaches them.
  always_comb begin
    tap_valid_o = r_valid;
    tap_data_o  = r_data;
    tap_pad_o   = r_pad;
    tap_last_o  = r_valid & (r_rem == '0);
    busy_o      = (r_state != ST_IDLE);
    done_o      = (r_state == ST_DONE);
  end

endmodule

// File: tb/tb_tcn_tap_sequencer.sv
// Self-checking bench for tcn_tap_sequencer: directed corner cases followed
// by randomized sequences checked against an arithmetic tap model.
module tb_tcn_tap_sequencer;

  localparam int DEPTH = 48;
  localparam int PW    = 80;
  localparam int KMAX  = 3;
  localparam int DW    = $clog2(DEPTH);
  localparam int NW    = $clog2(KMAX + 1);

  logic                         clk_i;
  logic                         rst_ni;
  logic [0:DEPTH-1][PW-1:0]     window_i;
  logic                         start_i;
  logic [DW-1:0]                dilation_i;
  logic [NW-1:0]                num_taps_i;
  logic                         tap_valid_o;
  logic                         tap_ready_i;
  logic [PW-1:0]                tap_data_o;
  logic                         tap_pad_o;
  logic                         tap_last_o;
  logic                         busy_o;
  logic                         done_o;

  int n_assert = 0;
  int n_fail   = 0;

  tcn_tap_sequencer #(
    .DEPTH               (DEPTH),
    .PHYSICALBITSPERWORD (PW),
    .KMAX                (KMAX)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .window_i    (window_i),
    .start_i     (start_i),
    .dilation_i  (dilation_i),
    .num_taps_i  (num_taps_i),
    .tap_valid_o (tap_valid_o),
    .tap_ready_i (tap_ready_i),
    .tap_data_o  (tap_data_o),
    .tap_pad_o   (tap_pad_o),
    .tap_last_o  (tap_last_o),
    .busy_o      (busy_o),
    .done_o      (done_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fill_index();
    for (int i = 0; i < DEPTH; i++) window_i[i] = PW'(i);
  endtask

  task automatic fill_random();
    for (int i = 0; i < DEPTH; i++)
      window_i[i] = PW'({$urandom, $urandom, $urandom});
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_valid"}, PW'(tap_valid_o), '0);
    chk({tag, "_data"},  tap_data_o,       '0);
    chk({tag, "_pad"},   PW'(tap_pad_o),   '0);
    chk({tag, "_last"},  PW'(tap_last_o),  '0);
    chk({tag, "_busy"},  PW'(busy_o),      '0);
    chk({tag, "_done"},  PW'(done_o),      '0);
  endtask

  // One full sequence. The model: tap k sits at offset (n-1-k)*d from the
  // newest word; offsets past the oldest word read as zero with pad set.
  // Outputs are sampled on falling edges, inputs driven there too.
  task automatic run_seq(input int n, input int d, input int stall_pct,
                         input int stall_tap, input int stall_cyc,
                         input bit inj, output int vcyc);
    logic [PW-1:0] ed [KMAX];
    bit            ep [KMAX];
    int            off;
    int            k;
    int            stalled;
    bit            rdy;
    for (int j = 0; j < n; j++) begin
      off   = (n - 1 - j) * d;
      ep[j] = (off > DEPTH - 1);
      ed[j] = ep[j] ? '0 : window_i[DEPTH - 1 - off];
    end
    vcyc    = 0;
    stalled = 0;
    k       = 0;
    @(negedge clk_i);
    start_i     = 1'b1;
    dilation_i  = DW'(d);
    num_taps_i  = NW'(n);
    tap_ready_i = 1'b0;
    @(negedge clk_i);
    start_i = 1'b0;
    while (k < n && vcyc < 100) begin
      chk("tap_valid", PW'(tap_valid_o), PW'(1));
      chk("tap_data",  tap_data_o,       ed[k]);
      chk("tap_pad",   PW'(tap_pad_o),   PW'(ep[k]));
      chk("tap_last",  PW'(tap_last_o),  PW'(k == n - 1));
      chk("busy_emit", PW'(busy_o),      PW'(1));
      chk("done_emit", PW'(done_o),      '0);
      if (k == stall_tap && stalled < stall_cyc) begin
        rdy = 1'b0;
        stalled++;
      end else if (stall_pct > 0) begin
        rdy = ($urandom_range(99) >= stall_pct);
      end else begin
        rdy = 1'b1;
      end
      if (inj && vcyc == 1) begin
        start_i    = 1'b1;
        dilation_i = DW'((d + 7) % DEPTH);
        num_taps_i = NW'(1);
      end else begin
        start_i = 1'b0;
      end
      tap_ready_i = rdy;
      @(negedge clk_i);
      vcyc++;
      if (rdy) k++;
    end
    start_i     = 1'b0;
    tap_ready_i = 1'b0;
    chk("seq_completed_taps", PW'(k),           PW'(n));
    chk("done_pulse",         PW'(done_o),      PW'(1));
    chk("done_valid",         PW'(tap_valid_o), '0);
    chk("done_busy",          PW'(busy_o),      PW'(1));
    @(negedge clk_i);
    chk("after_done_pulse", PW'(done_o), '0);
    chk("after_done_busy",  PW'(busy_o), '0);
  endtask

  initial begin
    int vc;
    int rn;
    int rd;
    rst_ni      = 1'b0;
    start_i     = 1'b0;
    dilation_i  = '0;
    num_taps_i  = '0;
    tap_ready_i = 1'b0;
    fill_index();

    repeat (2) @(negedge clk_i);
    chk_idle_zero("reset");
    rst_ni = 1'b1;
    @(negedge clk_i);
    chk_idle_zero("post_reset");

    // Index-valued window: taps 39,43,47, no bubbles.
    run_seq(3, 4, 0, -1, 0, 1'b0, vc);
    chk("d4_valid_cycles", PW'(vc), PW'(3));

    // First tap padded, then words 23 and 47.
    run_seq(3, 24, 0, -1, 0, 1'b0, vc);
    // Largest spacing that stays inside the window.
    run_seq(3, 20, 0, -1, 0, 1'b0, vc);
    run_seq(3, 23, 0, -1, 0, 1'b0, vc);

    // Consumer stalls two cycles on tap1: five valid cycles in total.
    run_seq(3, 1, 0, 1, 2, 1'b0, vc);
    chk("stall_valid_cycles", PW'(vc), PW'(5));

    // start_i during EMIT with another configuration is ignored.
    run_seq(3, 2, 0, -1, 0, 1'b1, vc);
    chk("inj_valid_cycles", PW'(vc), PW'(3));

    // Zero taps: done one cycle after start, tap_valid_o never high.
    run_seq(0, 5, 0, -1, 0, 1'b0, vc);
    chk("zero_taps_cycles", PW'(vc), '0);

    // Reset in the middle of tap1.
    @(negedge clk_i);
    start_i     = 1'b1;
    dilation_i  = DW'(4);
    num_taps_i  = NW'(3);
    tap_ready_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    chk("pre_rst_tap0", tap_data_o, PW'(39));
    @(negedge clk_i);
    chk("pre_rst_tap1", tap_data_o, PW'(43));
    rst_ni = 1'b0;
    #1;
    chk_idle_zero("mid_reset");
    @(negedge clk_i);
    rst_ni      = 1'b1;
    tap_ready_i = 1'b0;
    @(negedge clk_i);
    chk_idle_zero("mid_reset_release");
    run_seq(3, 4, 0, -1, 0, 1'b0, vc);
    chk("post_rst_valid_cycles", PW'(vc), PW'(3));

    // Zero dilation: all three taps are the newest word.
    run_seq(3, 0, 0, -1, 0, 1'b0, vc);

    // Randomized sequences over random windows with random back-pressure.
    for (int it = 0; it < 40; it++) begin
      fill_random();
      rn = $urandom_range(KMAX);
      rd = $urandom_range(DEPTH - 1);
      run_seq(rn, rd, 35, -1, 0, ($urandom_range(3) == 0), vc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/tcn_tap_sequencer.md
TCN_TAP_SEQUENCER -- requirements
Module: tcn_tap_sequencer

Interface
REQ-001 Parameter DEPTH, default 48, number of words in the TCN history window.
REQ-002 Parameter PHYSICALBITSPERWORD, default 80, width of one activation word.
REQ-003 Parameter KMAX, default 3, maximum TCN kernel taps per sequence.
REQ-004 clk_i  in  1  clock, rising edge.
REQ-005 rst_ni  in  1  reset, asynchronous, active-low.
REQ-006 window_i  in  [0:DEPTH-1][PHYSICALBITSPERWORD]  history window from the TCN shift memory; index DEPTH-1 is newest.
REQ-007 start_i  in  1  single-cycle request to emit one tap sequence.
REQ-008 dilation_i  in  clog2(DEPTH)  tap spacing in words, sampled with start_i.
REQ-009 num_taps_i  in  clog2(KMAX+1)  taps in the sequence, 0..KMAX, sampled with start_i.
REQ-010 tap_valid_o  out  1  tap word available.
REQ-011 tap_ready_i  in  1  consumer accepts the tap.
REQ-012 tap_data_o  out  PHYSICALBITSPERWORD  tap word; zero when padded.
REQ-013 tap_pad_o  out  1  tap lies before the window start and is zero-padded.
REQ-014 tap_last_o  out  1  final tap of the sequence.
REQ-015 busy_o  out  1  sequence in progress; upstream shall not write the shift memory while high.
REQ-016 done_o  out  1  single-cycle pulse after the last tap handshake.

Function
REQ-017 FSM states: IDLE, EMIT, DONE; reset state IDLE.
REQ-018 IDLE: start_i=1 latches dilation_i/num_taps_i; num_taps_i>0 -> EMIT; num_taps_i=0 -> DONE, with no tap emitted.
REQ-019 start_i outside IDLE is ignored; latched configuration is unchanged.
REQ-020 Taps are emitted oldest-first: tap k (k=0..n-1) uses offset (n-1-k)*dilation and index DEPTH-1-offset.
REQ-021 The offset register shall be at least clog2(DEPTH)+clog2(KMAX)+1 bits wide; it is initialised to (n-1)*dilation and decremented by dilation per handshake, with no wrap-around.
REQ-022 Offset > DEPTH-1: tap_data_o=0 and tap_pad_o=1; otherwise tap_data_o=window_i[index] and tap_pad_o=0.
REQ-023 The tap register is loaded from window_i on the cycle of start acceptance or of a non-last handshake; tap_valid_o is high the next cycle, giving one tap per cycle with no bubbles when tap_ready_i=1.
REQ-024 While tap_valid_o=1 and tap_ready_i=0, tap_data_o, tap_pad_o and tap_last_o hold stable and the offset does not advance.
REQ-025 tap_last_o=1 only on tap n-1; a handshake on it moves EMIT->DONE.
REQ-026 DONE: done_o=1 for exactly one cycle, then IDLE; tap_valid_o=0 in DONE.
REQ-027 busy_o=1 in EMIT and DONE, 0 in IDLE.
REQ-028 dilation_i=0 is legal: all taps read index DEPTH-1.
REQ-029 tap_valid_o is independent of tap_ready_i; there is no combinational path from tap_ready_i to any output.

Reset
REQ-030 Asserting rst_ni (low) at any time, including mid-EMIT, forces IDLE and sets tap_valid_o, tap_data_o, tap_pad_o, tap_last_o, busy_o and done_o to 0.
REQ-031 The latched configuration and offset reset to 0; the partial sequence is discarded and not resumed.

Structure
REQ-032 DEPTH, PHYSICALBITSPERWORD, KMAX defaults and the FSM state enum type shall reside in the shared TCN package tcn_pkg.
REQ-033 The block is a single module with no sub-modules; index/pad computation is inline combinational logic.

Verification
REQ-034 window_i[i]=i, n=3, dilation=4, ready=1, start at cycle c -> taps 39,43,47 at c+1..c+3, last at c+3, done at c+4.
REQ-035 n=3, dilation=24 -> tap0 zero with pad=1, then words 23,47; dilation=20 -> 7,27,47 with no pad.
REQ-036 n=3, dilation=1, ready low for 2 cycles on tap1 -> tap1=46 held stable for 3 cycles, tap2=47 follows, total 5 valid cycles.
REQ-037 start_i pulsed during EMIT with different config -> ignored; num_taps=0 -> done at c+1, tap_valid_o never asserted.
REQ-038 rst_ni low during tap1 -> all outputs 0 and IDLE; a new start after reset gives a clean full sequence.
REQ-039 dilation=0, n=3 -> three taps equal to word 47, pad=0.
